ppg_sequencer: RTL and testbench
================================

PPG_SEQUENCER -- requirements
Module: ppg_sequencer

Interface
REQ-001 Parameter I, default 10: number of rows of A and residual entries.
REQ-002 Parameter J, default 2: number of columns of A and solution entries.
REQ-003 Parameter N, default 8: fixed-point word width.
REQ-004 Parameter Q, default 3: fractional bits; carried to Iterate only, no local fixed-point arithmetic.
REQ-005 Parameter MAX_ITER, default 64: outer-iteration limit, at least 1.
REQ-006 Parameter TOL_SHIFT, default 4: relative tolerance 2^-TOL_SHIFT.
REQ-007 Parameter WAIT_MAX, default 255: watchdog limit in cycles per Iterate pass.
REQ-008 Ports: clk in 1, clock; rising edge only.
REQ-009 Ports: rst_n in 1, reset; one clock, asynchronous, active-low.
REQ-010 Ports: go in 1, request a new solve; b in [I][N], initial residual.
REQ-011 Ports: it_start out 1, start pulse to Iterate; it_done in 1, Iterate done level.
REQ-012 Ports: it_xhat_in out [J][N]; it_r_in out [I][N]; it_max_xj_in out N.
REQ-013 Ports: it_xhat_out in [J][N]; it_r_out in [I][N]; it_max_xj_out in N; it_max_dxj_out in N.
REQ-014 Ports: x_result out [J][N]; iter_count out 8; busy out 1; done out 1; converged out 1; timeout out 1.

Function
REQ-015 States: IDLE, LOAD, START, WAIT, EVAL, FIN.
REQ-016 IDLE: go=1 moves to LOAD; go ignored in every other state.
REQ-017 LOAD, one cycle: r_reg<=b, xhat_reg<=0, max_xj_reg<=0, iter_count<=0, wdog<=0, converged<=0, timeout<=0; next START.
REQ-018 START, one cycle: it_start=1, wdog<=0; next WAIT. it_start=0 in all other states.
REQ-019 it_xhat_in, it_r_in and it_max_xj_in are continuously driven from xhat_reg, r_reg and max_xj_reg.
REQ-020 WAIT: a completion is an it_done 0->1 edge, detected against a registered copy of it_done; a level held over from the previous pass is not a completion.
REQ-021 On completion: xhat_reg<=it_xhat_out, r_reg<=it_r_out, max_xj_reg<=it_max_xj_out, dxj_reg<=it_max_dxj_out, iter_count+=1; next EVAL.
REQ-022 WAIT without completion: wdog increments; at wdog==WAIT_MAX, timeout<=1 and next FIN.
REQ-023 EVAL: conv = (dxj_reg <= (max_xj_reg >> TOL_SHIFT)), unsigned compare on N bits.
REQ-024 EVAL exits: conv=1 -> converged<=1, FIN; else iter_count==MAX_ITER -> FIN, converged stays 0; else START.
REQ-025 FIN, one cycle: done=1, then IDLE.
REQ-026 Pass latency: START to completion edge plus 2 cycles (capture, EVAL) before the next START.
REQ-027 x_result=xhat_reg at all times; iter_count, converged and timeout hold until the next LOAD.
REQ-028 busy=1 in LOAD, START, WAIT, EVAL, FIN; 0 in IDLE.
REQ-029 Completion edge and watchdog limit in the same cycle: completion wins, timeout stays 0.

Reset
REQ-030 rst_n low asynchronously forces IDLE and clears every register: xhat_reg, r_reg, max_xj_reg, dxj_reg, wdog, iter_count, the it_done history bit and all outputs (it_start, busy, done, converged, timeout, x_result).
REQ-031 Reset during WAIT aborts the solve; after release, go is required to start again.

Structure
REQ-032 Shared package ppg_pkg holds the state enum, word-width constants and the array typedefs for [I][N] and [J][N].
REQ-033 One sub-module, ppg_conv_check: combinational REQ-023 compare with TOL_SHIFT as parameter.
REQ-034 Iterate is instantiated outside the sequencer and connected through the it_* ports.

Verification
REQ-035 Reset, then go with b={44,50,74,0C,08,26,D4,C0,EC,8C}h -> it_start pulses 2 cycles after go; it_r_in equals b.
REQ-036 Model returns dxj=01, max_xj=40 on pass 1 -> converged=1, iter_count=1, done pulse 2 cycles after the it_done edge.
REQ-037 Model always returns dxj=40, max_xj=40, MAX_ITER=3 -> exactly 3 it_start pulses, done with converged=0, iter_count=3.
REQ-038 Model holds it_done=1 from pass 1 -> pass 2 waits for a new edge; stuck-high gives timeout=1 after WAIT_MAX=255 cycles.
REQ-039 rst_n pulsed low mid-WAIT -> all outputs 0 immediately; a later go restarts at iter_count 0.
REQ-040 go held high through FIN -> a new solve starts only after IDLE is reached; no extra it_start in EVAL or FIN.

Source files
------------

// File: rtl/ppg_pkg.sv
// Shared types and default sizes for the PPG solve sequencer.
package ppg_pkg;

   localparam int PPG_I = 10;
   localparam int PPG_J = 2;
   localparam int PPG_N = 8;

   typedef logic [PPG_I-1:0][PPG_N-1:0] r_vec_t;
   typedef logic [PPG_J-1:0][PPG_N-1:0] x_vec_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      EVAL,
      FIN
   } state_t;

endpackage

// File: rtl/ppg_conv_check.sv
// Relative-tolerance convergence test: largest step against largest estimate scaled by 2^-TOL_SHIFT.
module ppg_conv_check #(
   parameter int N         = 8,
   parameter int TOL_SHIFT = 4
) (
   input  logic [N-1:0] dxj,
   input  logic [N-1:0] max_xj,
   output logic         conv
);

   assign conv = (dxj <= (max_xj >> TOL_SHIFT));

endmodule

// File: rtl/ppg_sequencer.sv
// Outer-loop controller: repeatedly launches an external Iterate pass until convergence, iteration limit or watchdog.
module ppg_sequencer
   import ppg_pkg::*;
#(
   parameter int I         = PPG_I,
   parameter int J         = PPG_J,
   parameter int N         = PPG_N,
   parameter int Q         = 3,
   parameter int MAX_ITER  = 64,
   parameter int TOL_SHIFT = 4,
   parameter int WAIT_MAX  = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                go,
   input  logic [I-1:0][N-1:0] b,
   output logic                it_start,
   input  logic                it_done,
   output logic [J-1:0][N-1:0] it_xhat_in,
   output logic [I-1:0][N-1:0] it_r_in,
   output logic [N-1:0]        it_max_xj_in,
   input  logic [J-1:0][N-1:0] it_xhat_out,
   input  logic [I-1:0][N-1:0] it_r_out,
   input  logic [N-1:0]        it_max_xj_out,
   input  logic [N-1:0]        it_max_dxj_out,
   output logic [J-1:0][N-1:0] x_result,
   output logic [7:0]          iter_count,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic                timeout
);

   localparam int WW = $clog2(WAIT_MAX + 1);

   // Q belongs to the Iterate datapath; it is only sanity-checked here.
   if (Q >= N || MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_params
      $error("ppg_sequencer: illegal parameter combination");
   end

   state_t               state, state_nxt;
   logic [J-1:0][N-1:0]  xhat_reg;
   logic [I-1:0][N-1:0]  r_reg;
   logic [N-1:0]         max_xj_reg;
   logic [N-1:0]         dxj_reg;
   logic [WW-1:0]        wdog;
   logic                 done_q;
   logic                 done_rise;
   logic                 conv;
   logic                 wdog_hit;

   assign done_rise    = it_done & ~done_q;
   assign wdog_hit     = (wdog == WW'(WAIT_MAX));
   assign it_xhat_in   = xhat_reg;
   assign it_r_in      = r_reg;
   assign it_max_xj_in = max_xj_reg;
   assign x_result     = xhat_reg;

   ppg_conv_check #(
      .N         (N),
      .TOL_SHIFT (TOL_SHIFT)
   ) u_conv (
      .dxj    (dxj_reg),
      .max_xj (max_xj_reg),
      .conv   (conv)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      it_start  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (go) state_nxt = LOAD;
         end
         LOAD:  state_nxt = START;
         START: begin
            it_start  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (done_rise)     state_nxt = EVAL;
            else if (wdog_hit) state_nxt = FIN;
         end
         EVAL: begin
            if (conv)                          state_nxt = FIN;
            else if (iter_count == 8'(MAX_ITER)) state_nxt = FIN;
            else                               state_nxt = START;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         xhat_reg   <= '0;
         r_reg      <= '0;
         max_xj_reg <= '0;
         dxj_reg    <= '0;
         wdog       <= '0;
         iter_count <= '0;
         done_q     <= 1'b0;
         converged  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= it_done;
         unique case (state)
            LOAD: begin
               r_reg      <= b;
               xhat_reg   <= '0;
               max_xj_reg <= '0;
               iter_count <= '0;
               wdog       <= '0;
               converged  <= 1'b0;
               timeout    <= 1'b0;
            end
            START: wdog <= '0;
            WAIT: begin
               // A completion in the watchdog's final cycle still counts.
               if (done_rise) begin
                  xhat_reg   <= it_xhat_out;
                  r_reg      <= it_r_out;
                  max_xj_reg <= it_max_xj_out;
                  dxj_reg    <= it_max_dxj_out;
                  iter_count <= iter_count + 8'd1;
               end else if (wdog_hit) begin
                  timeout <= 1'b1;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            EVAL: if (conv) converged <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ppg_sequencer.sv
// Directed bench for ppg_sequencer with a hand-driven Iterate model.
module tb_ppg_sequencer;
   import ppg_pkg::*;

   localparam int I = PPG_I;
   localparam int J = PPG_J;
   localparam int N = PPG_N;

   logic                clk;
   logic                rst_n;
   logic                go;
   r_vec_t              b;
   logic                it_start;
   logic                it_done;
   x_vec_t              it_xhat_in;
   r_vec_t              it_r_in;
   logic [N-1:0]        it_max_xj_in;
   x_vec_t              it_xhat_out;
   r_vec_t              it_r_out;
   logic [N-1:0]        it_max_xj_out;
   logic [N-1:0]        it_max_dxj_out;
   x_vec_t              x_result;
   logic [7:0]          iter_count;
   logic                busy;
   logic                done;
   logic                converged;
   logic                timeout;

   int vectors = 0;
   int miscompares = 0;
   int starts = 0;

   ppg_sequencer #(
      .I(I), .J(J), .N(N), .Q(3), .MAX_ITER(3), .TOL_SHIFT(4), .WAIT_MAX(255)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .go             (go),
      .b              (b),
      .it_start       (it_start),
      .it_done        (it_done),
      .it_xhat_in     (it_xhat_in),
      .it_r_in        (it_r_in),
      .it_max_xj_in   (it_max_xj_in),
      .it_xhat_out    (it_xhat_out),
      .it_r_out       (it_r_out),
      .it_max_xj_out  (it_max_xj_out),
      .it_max_dxj_out (it_max_dxj_out),
      .x_result       (x_result),
      .iter_count     (iter_count),
      .busy           (busy),
      .done           (done),
      .converged      (converged),
      .timeout        (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (it_start) starts++;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int s0;
      int n;
      r_vec_t r_next;

      rst_n = 1'b0;
      go = 1'b0;
      it_done = 1'b0;
      b = {8'h44, 8'h50, 8'h74, 8'h0C, 8'h08, 8'h26, 8'hD4, 8'hC0, 8'hEC, 8'h8C};
      it_xhat_out = '0;
      it_r_out = '0;
      it_max_xj_out = '0;
      it_max_dxj_out = '0;
      r_next = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};

      // Reset state
      cycle(); cycle();
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst it_start", it_start, 0);
      check("rst x_result", x_result, 0);
      check("rst iter_count", iter_count, 0);
      check("rst converged", converged, 0);
      check("rst timeout", timeout, 0);
      rst_n = 1'b1;
      cycle();

      // Single pass converging immediately
      go = 1'b1;
      cycle();
      go = 1'b0;
      check("t1 LOAD busy", busy, 1);
      check("t1 LOAD no start", it_start, 0);
      cycle();
      check("t1 it_start", it_start, 1);
      check("t1 it_r_in=b", it_r_in, b);
      check("t1 it_xhat_in=0", it_xhat_in, 0);
      it_xhat_out = {8'h12, 8'h34};
      it_r_out = r_next;
      it_max_xj_out = 8'h40;
      it_max_dxj_out = 8'h01;
      cycle();
      check("t1 WAIT no start", it_start, 0);
      cycle(); cycle();
      it_done = 1'b1;
      cycle();
      check("t1 EVAL done", done, 0);
      check("t1 x_result", x_result, 16'h1234);
      check("t1 it_r_in", it_r_in, r_next);
      check("t1 it_max_xj_in", it_max_xj_in, 8'h40);
      check("t1 iter_count", iter_count, 1);
      cycle();
      check("t1 done", done, 1);
      check("t1 converged", converged, 1);
      cycle();
      it_done = 1'b0;
      check("t1 idle done", done, 0);
      check("t1 idle busy", busy, 0);
      check("t1 converged hold", converged, 1);

      // Never converges, iteration limit 3, go held high throughout
      it_max_xj_out = 8'h40;
      it_max_dxj_out = 8'h40;
      it_xhat_out = {8'h0A, 8'h0B};
      s0 = starts;
      go = 1'b1;
      cycle(); cycle();
      check("t2 first start", it_start, 1);
      check("t2 converged cleared", converged, 0);
      for (int p = 1; p <= 3; p++) begin
         cycle(); cycle();
         it_done = 1'b1;
         cycle();
         it_done = 1'b0;
         check("t2 EVAL no start", it_start, 0);
         check("t2 iter_count", iter_count, 8'(p));
         cycle();
         if (p < 3) begin
            check("t2 pass latency start", it_start, 1);
         end else begin
            check("t2 done", done, 1);
            check("t2 FIN no start", it_start, 0);
            check("t2 not converged", converged, 0);
            check("t2 iter_count final", iter_count, 3);
            check("t2 no timeout", timeout, 0);
         end
      end
      cycle();
      check("t2 idle reached", busy, 0);
      check("t2 start pulses", starts - s0, 3);
      cycle();
      go = 1'b0;
      check("t2 relaunch LOAD", busy, 1);
      cycle();
      check("t2 relaunch start", it_start, 1);
      it_max_dxj_out = 8'h01;
      cycle();
      it_done = 1'b1;
      cycle(); cycle();
      it_done = 1'b0;
      check("t2 relaunch done", done, 1);
      check("t2 relaunch converged", converged, 1);
      cycle();

      // it_done held high after pass 1: pass 2 must time out
      it_xhat_out = {8'h5A, 8'h5A};
      it_max_dxj_out = 8'h40;
      go = 1'b1;
      cycle();
      go = 1'b0;
      cycle();
      cycle(); cycle();
      it_done = 1'b1;
      cycle(); cycle();
      check("t3 pass2 start", it_start, 1);
      n = 0;
      while (!done && n < 400) begin
         cycle();
         n++;
      end
      check("t3 watchdog cycles", n, 257);
      check("t3 timeout", timeout, 1);
      check("t3 iter_count", iter_count, 1);
      check("t3 not converged", converged, 0);
      check("t3 x_result", x_result, 16'h5A5A);
      cycle();
      check("t3 idle busy", busy, 0);
      check("t3 timeout hold", timeout, 1);
      it_done = 1'b0;
      cycle();

      // Reset in the middle of pass 2
      it_xhat_out = {8'hA5, 8'h5A};
      go = 1'b1;
      cycle();
      go = 1'b0;
      cycle();
      check("t4 timeout cleared", timeout, 0);
      check("t4 iter_count cleared", iter_count, 0);
      cycle(); cycle();
      it_done = 1'b1;
      cycle();
      it_done = 1'b0;
      cycle(); cycle(); cycle();
      check("t4 pre-reset iter", iter_count, 1);
      check("t4 pre-reset x", x_result, 16'hA55A);
      rst_n = 1'b0;
      #1;
      check("t4 async busy", busy, 0);
      check("t4 async x_result", x_result, 0);
      check("t4 async iter_count", iter_count, 0);
      check("t4 async it_r_in", it_r_in, 0);
      check("t4 async done", done, 0);
      cycle();
      rst_n = 1'b1;
      cycle(); cycle(); cycle();
      check("t4 waits for go", busy, 0);

      // Completion on the watchdog's last cycle wins over timeout
      it_xhat_out = {8'h0F, 8'h0F};
      it_max_dxj_out = 8'h01;
      go = 1'b1;
      cycle();
      go = 1'b0;
      cycle();
      check("t5 start", it_start, 1);
      check("t5 iter_count", iter_count, 0);
      for (int k = 0; k < 256; k++) cycle();
      check("t5 still waiting", busy & ~done, 1);
      it_done = 1'b1;
      cycle();
      it_done = 1'b0;
      check("t5 iter_count", iter_count, 1);
      check("t5 no timeout", timeout, 0);
      cycle();
      check("t5 done", done, 1);
      check("t5 converged", converged, 1);
      check("t5 x_result", x_result, 16'h0F0F);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
